mod_red_sched: RTL
==================

MOD_RED_SCHED -- requirements
Module: mod_red_sched

Interface
REQ-001 The block SHALL have parameter K, default 120, meaning the input operand C width in bits.
REQ-002 The block SHALL have parameter Q_LEN, default 60, meaning the modulus and result width in bits.
REQ-003 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters; legal range is 2..8.
REQ-004 The block SHALL have parameter RED_LAT, default 6, meaning the reduction datapath latency from red_C to red_T in cycles; it must be at least 1.
REQ-005 The block SHALL have ports as follows; ID_W is clog2(N_REQ) and CNT_W is clog2(RED_LAT+3).
- clk  in  1  clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester operand valid
- req_data  in  N_REQ*K  operands; requester i occupies bits [i*K +: K]
- req_ready  out  N_REQ  one-hot grant
- cfg_we  in  1  modulus load strobe
- cfg_q  in  Q_LEN  new modulus
- cfg_busy  out  1  modulus change in progress
- red_vld  out  1  red_C carries a new operation this cycle
- red_C  out  K  operand to the reduction datapath
- red_q  out  Q_LEN  modulus to the reduction datapath
- red_T  in  Q_LEN  result from the reduction datapath
- res_valid  out  1  result strobe
- res_id  out  ID_W  index of the requester that issued the operation
- res_data  out  Q_LEN  reduced result
- inflight  out  CNT_W  count of accepted operations not yet returned

Function
REQ-006 Arbitration SHALL be round-robin with at most one grant per cycle; req_ready is combinational and is asserted only toward a requester whose req_valid is high.
REQ-007 The search SHALL start at pointer p; after a transfer by requester i, p becomes (i+1) mod N_REQ; p is unchanged in cycles with no transfer.
REQ-008 A transfer SHALL be defined as req_valid[i] and req_ready[i] both high in a cycle.
REQ-009 For a transfer in cycle t, red_C SHALL equal that requester's req_data, and red_vld SHALL be 1, in cycle t+1.
REQ-010 red_C SHALL hold its last value when there is no transfer, and red_vld SHALL be 0 in that case.
REQ-011 The block SHALL carry each operation's valid bit and ID through a tag shift pipeline aligned to RED_LAT.
REQ-012 red_T SHALL be registered into res_data, so res_valid, res_id and res_data appear in cycle t+2+RED_LAT; total latency is RED_LAT+2.
REQ-013 res_valid SHALL be a single-cycle pulse per operation; no backpressure exists, and results are returned in issue order.
REQ-014 inflight SHALL increment on a transfer and decrement on res_valid; if both happen in the same cycle it stays unchanged.
REQ-015 The FSM SHALL have the states RUN, DRAIN and LOAD.
REQ-016 In RUN, cfg_we=1 SHALL capture cfg_q, force req_ready to all-zero in that same cycle, and move the FSM to DRAIN.
REQ-017 DRAIN SHALL grant nothing and SHALL move to LOAD in the first cycle in which inflight is 0.
REQ-018 LOAD SHALL write the captured value into red_q, grant nothing, and return to RUN on the next cycle.
REQ-019 cfg_busy SHALL be 1 in DRAIN and LOAD.
REQ-020 cfg_we SHALL be ignored while cfg_busy is 1.
REQ-021 red_q SHALL change only in LOAD, so no in-flight operation ever sees a modulus change.
REQ-022 If there are no valid requesters, the block SHALL make no grant and p SHALL be unchanged.

Reset
REQ-023 The following SHALL be cleared asynchronously while rst is high: req_ready, red_vld, red_C, red_q, res_valid, res_id, res_data, inflight, cfg_busy, p, all tag pipeline valid bits, the captured modulus, and any counter; the FSM SHALL go to RUN.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight tags; no res_valid may appear after release for any operation accepted before reset.

Configuration
REQ-025 When the macro MOD_RED_SCHED_PERF_EN is defined, the block SHALL add an output op_count of 32 bits that increments on every transfer, wraps from 2^32-1 to 0, and resets to 0.
REQ-026 When MOD_RED_SCHED_PERF_EN is undefined, op_count and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Single request: N_REQ=4, RED_LAT=6, req_valid=0001 at t=0, C=0x5 -> req_ready[0]=1 at t=0; red_vld=1, red_C=0x5 at t=1; res_valid=1, res_id=0, res_data=red_T at t=8; inflight returns to 0.
REQ-028 Fairness: req_valid=1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; res_id follows the same order; peak inflight=8.
REQ-029 Modulus change under load: cfg_we=1 with cfg_q=0xABC while inflight=3 -> no grants until all 3 results return; red_q=0xABC only after the last res_valid; cfg_busy falls one cycle after LOAD; a second cfg_we during DRAIN is ignored.
REQ-030 Simultaneous events: a transfer in the same cycle as a res_valid -> inflight unchanged.
REQ-031 Reset: rst pulsed while inflight=5 -> all outputs 0 at once; no res_valid after release; p=0, so requester 0 is granted first.
REQ-032 PERF_EN: with the macro defined, 10 transfers -> op_count=10; counter preloaded to 0xFFFFFFFF, then 1 transfer -> op_count=0.

Source files
------------

// File: rtl/mod_red_sched_if.sv
// Requester/result bus of mod_red_sched: per-requester operands in, one-hot grant back,
// and the in-order result strobe. master = requester side, slave = scheduler side.
interface mod_red_sched_if #(
   parameter int N_REQ = 4,
   parameter int K     = 120,
   parameter int Q_LEN = 60
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ*K-1:0] req_data;
   logic [N_REQ-1:0]   req_ready;
   logic               res_valid;
   logic [ID_W-1:0]    res_id;
   logic [Q_LEN-1:0]   res_data;

   modport master (
      output req_valid, req_data,
      input  req_ready, res_valid, res_id, res_data
   );

   modport slave (
      input  req_valid, req_data,
      output req_ready, res_valid, res_id, res_data
   );
endinterface

// File: rtl/mod_red_sched.sv
// Round-robin scheduler in front of a fixed-latency modular-reduction datapath; modulus
// updates drain all in-flight work first. Define MOD_RED_SCHED_PERF_EN to add op_count.
module mod_red_sched #(
   parameter int K        = 120,
   parameter int Q_LEN    = 60,
   parameter int N_REQ    = 4,
   parameter int RED_LAT  = 6,
   localparam int ID_W    = $clog2(N_REQ),
   localparam int CNT_W   = $clog2(RED_LAT + 3)
) (
   input  logic               clk,
   input  logic               rst,
   mod_red_sched_if.slave     bus,
   input  logic               cfg_we,
   input  logic [Q_LEN-1:0]   cfg_q,
   output logic               cfg_busy,
   output logic               red_vld,
   output logic [K-1:0]       red_C,
   output logic [Q_LEN-1:0]   red_q,
   input  logic [Q_LEN-1:0]   red_T,
   output logic [CNT_W-1:0]   inflight
`ifdef MOD_RED_SCHED_PERF_EN
   ,
   output logic [31:0]        op_count
`endif
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      LOAD  = 2'd2
   } state_t;

   state_t                   state_r;
   state_t                   state_nxt_s;
   logic [ID_W-1:0]          ptr_r;
   logic [N_REQ-1:0]         gnt_s;
   logic [ID_W-1:0]          gnt_id_s;
   logic                     grant_en_s;
   logic                     found_s;
   logic                     xfer_s;
   logic [ID_W:0]            idx_s;
   logic [K-1:0]             sel_data_s;
   logic [K-1:0]             red_c_r;
   logic [Q_LEN-1:0]         q_cap_r;
   logic [Q_LEN-1:0]         red_q_r;
   logic [RED_LAT:0]         tag_vld_r;
   logic [RED_LAT:0][ID_W-1:0] tag_id_r;
   logic                     res_valid_r;
   logic [ID_W-1:0]          res_id_r;
   logic [Q_LEN-1:0]         res_data_r;
   logic [CNT_W-1:0]         inflight_r;
   logic                     cfg_busy_r;

   // Grants are suppressed in reset, outside RUN, and in the cycle a modulus load is requested.
   assign grant_en_s = (state_r == RUN) && !cfg_we && !rst;
   assign xfer_s     = |gnt_s;

   // Round-robin search beginning at ptr_r; the first valid requester found wins.
   always_comb begin
      gnt_s    = '0;
      gnt_id_s = '0;
      found_s  = 1'b0;
      idx_s    = '0;
      for (int off = 0; off < N_REQ; off++) begin
         idx_s = {1'b0, ptr_r} + (ID_W+1)'(off);
         if (idx_s >= (ID_W+1)'(N_REQ)) begin
            idx_s = idx_s - (ID_W+1)'(N_REQ);
         end else begin
            idx_s = idx_s;
         end
         if (grant_en_s && !found_s && bus.req_valid[idx_s[ID_W-1:0]]) begin
            gnt_s[idx_s[ID_W-1:0]] = 1'b1;
            gnt_id_s               = idx_s[ID_W-1:0];
            found_s                = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // One-hot AND-OR selection of the granted operand.
   always_comb begin
      sel_data_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_data_s = sel_data_s | ({K{gnt_s[i]}} & bus.req_data[i*K +: K]);
      end
   end

   // Modulus-change sequencing: RUN -> DRAIN (until idle) -> LOAD -> RUN.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         RUN: begin
            if (cfg_we) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DRAIN: begin
            if (inflight_r == '0) begin
               state_nxt_s = LOAD;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         LOAD:    state_nxt_s = RUN;
         default: state_nxt_s = RUN;
      endcase
   end

   // State register and registered busy flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= RUN;
         cfg_busy_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cfg_busy_r <= (state_nxt_s != RUN);
      end
   end

   // Issue register, round-robin pointer, captured and active modulus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r   <= '0;
         red_c_r <= '0;
         q_cap_r <= '0;
         red_q_r <= '0;
      end else begin
         if (xfer_s) begin
            red_c_r <= sel_data_s;
            ptr_r   <= (gnt_id_s == ID_W'(N_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
         end
         if ((state_r == RUN) && cfg_we) begin
            q_cap_r <= cfg_q;
         end
         if (state_r == LOAD) begin
            red_q_r <= q_cap_r;
         end
      end
   end

   // Tag pipeline: stage 0 lines up with red_C, stage RED_LAT with red_T.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld_r   <= '0;
         tag_id_r    <= '0;
         res_valid_r <= 1'b0;
         res_id_r    <= '0;
         res_data_r  <= '0;
      end else begin
         tag_vld_r   <= {tag_vld_r[RED_LAT-1:0], xfer_s};
         tag_id_r    <= {tag_id_r[RED_LAT-1:0], gnt_id_s};
         res_valid_r <= tag_vld_r[RED_LAT];
         res_id_r    <= tag_id_r[RED_LAT];
         if (tag_vld_r[RED_LAT]) begin
            res_data_r <= red_T;
         end
      end
   end

   // Outstanding-operation counter; a simultaneous issue and return cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_r <= '0;
      end else begin
         case ({xfer_s, res_valid_r})
            2'b10:   inflight_r <= inflight_r + CNT_W'(1);
            2'b01:   inflight_r <= inflight_r - CNT_W'(1);
            default: inflight_r <= inflight_r;
         endcase
      end
   end

`ifdef MOD_RED_SCHED_PERF_EN
   logic [31:0] op_count_r;

   // Free-running transfer counter, wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count_r <= 32'd0;
      end else begin
         op_count_r <= op_count_r + 32'(xfer_s);
      end
   end

   assign op_count = op_count_r;
`endif

   assign bus.req_ready = gnt_s;
   assign bus.res_valid = res_valid_r;
   assign bus.res_id    = res_id_r;
   assign bus.res_data  = res_data_r;
   assign red_vld       = tag_vld_r[0];
   assign red_C         = red_c_r;
   assign red_q         = red_q_r;
   assign inflight      = inflight_r;
   assign cfg_busy      = cfg_busy_r;

endmodule
